// File: rtl/toom_operand_splitter.sv
// Operand splitter for the Toom-K evaluation stage: registers an operand pair and
// streams it out as zero-extended limb pairs, one pair per valid/ready handshake.
module toom_operand_splitter #(
    parameter int WIDTH     = 1024,
    parameter int K         = 8,
    parameter int GUARD     = 1,
    parameter int MSB_FIRST = 0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [WIDTH-1:0]                       X,
    input  logic [WIDTH-1:0]                       Y,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [((WIDTH+K-1)/K)+GUARD-1:0]       out_a,
    output logic [((WIDTH+K-1)/K)+GUARD-1:0]       out_b,
    output logic [((K > 2) ? $clog2(K) : 1)-1:0]   out_idx,
    output logic                                   out_last
);

    localparam int LIMB_W = (WIDTH + K - 1) / K;
    localparam int OUT_W  = LIMB_W + GUARD;
    localparam int IDX_W  = (K > 2) ? $clog2(K) : 1;
    localparam int PAD_W  = K * LIMB_W;

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PAD_W-1:0]   r_a;
    logic [PAD_W-1:0]   r_b;
    logic [IDX_W-1:0]   r_cnt;
    logic               w_fire;
    logic               w_last;
    logic               w_capture;
    logic [LIMB_W-1:0]  w_limb_a;
    logic [LIMB_W-1:0]  w_limb_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // in_ready opens on the final handshake so a new pair loads with no bubble
    always_comb begin
        w_state_nxt = r_state;
        out_valid   = (r_state == S_EMIT);
        w_last      = (r_cnt == IDX_W'(K - 1));
        w_fire      = out_valid && out_ready;
        in_ready    = (r_state == S_IDLE) || (w_fire && w_last);
        w_capture   = in_valid && in_ready;
        out_last    = w_last;
        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (w_fire && w_last) begin
                    w_state_nxt = w_capture ? S_EMIT : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (w_capture) begin
            r_a   <= PAD_W'(X);
            r_b   <= PAD_W'(Y);
            r_cnt <= '0;
        end else if (w_fire && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        if (MSB_FIRST != 0) begin
            out_idx = IDX_W'(K - 1) - r_cnt;
        end else begin
            out_idx = r_cnt;
        end
    end

    // Padding bits above WIDTH are zero, so the top limb needs no special case
    always_comb begin
        w_limb_a = '0;
        w_limb_b = '0;
        for (int unsigned i = 0; i < K; i++) begin
            if (out_idx == IDX_W'(i)) begin
                w_limb_a = r_a[i*LIMB_W +: LIMB_W];
                w_limb_b = r_b[i*LIMB_W +: LIMB_W];
            end
        end
        out_a = OUT_W'(w_limb_a);
        out_b = OUT_W'(w_limb_b);
    end

endmodule

// File: tb/tb_toom_operand_splitter.sv
// Bench for toom_operand_splitter: default, MSB-first and odd-width instances,
// scoreboard-checked limb streams plus hand-written multi-cycle sequences.
module tb_toom_operand_splitter;

    typedef struct packed {
        logic [128:0] a;
        logic [128:0] b;
        logic [2:0]   idx;
        logic         last;
    } exp_t;

    typedef struct {
        logic [1023:0] x;
        logic [1023:0] y;
    } dvec_t;

    typedef struct {
        logic [99:0] x;
        logic [99:0] y;
        logic [14:0] ea [8];
        logic [14:0] eb [8];
    } ovec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [1023:0] X = '0;
    logic [1023:0] Y = '0;
    logic          in_ready0, out_valid0, out_last0;
    logic [128:0]  out_a0, out_b0;
    logic [2:0]    out_idx0;
    logic          in_ready1, out_valid1, out_last1;
    logic [128:0]  out_a1, out_b1;
    logic [2:0]    out_idx1;

    logic          in_valid2 = 1'b0;
    logic          out_ready2 = 1'b1;
    logic [99:0]   X2 = '0;
    logic [99:0]   Y2 = '0;
    logic          in_ready2, out_valid2, out_last2;
    logic [14:0]   out_a2, out_b2;
    logic [2:0]    out_idx2;

    int   total = 0;
    int   bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic hold [2];
    exp_t saved [2];
    logic gap_watch = 1'b0;
    int   gap_cnt = 0;

    always #5 clk = ~clk;

    toom_operand_splitter #(.WIDTH(1024), .K(8), .GUARD(1), .MSB_FIRST(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .X(X), .Y(Y), .out_valid(out_valid0), .out_ready(out_ready),
        .out_a(out_a0), .out_b(out_b0), .out_idx(out_idx0), .out_last(out_last0));

    toom_operand_splitter #(.WIDTH(1024), .K(8), .GUARD(1), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .X(X), .Y(Y), .out_valid(out_valid1), .out_ready(out_ready),
        .out_a(out_a1), .out_b(out_b1), .out_idx(out_idx1), .out_last(out_last1));

    toom_operand_splitter #(.WIDTH(100), .K(8), .GUARD(2), .MSB_FIRST(0)) u_odd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .X(X2), .Y(Y2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_a(out_a2), .out_b(out_b2), .out_idx(out_idx2), .out_last(out_last2));

    task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic void push_exp(input logic [1023:0] x, input logic [1023:0] y);
        exp_t e;
        int   idx;
        for (int c = 0; c < 8; c++) begin
            for (int d = 0; d < 2; d++) begin
                idx    = (d == 0) ? c : 7 - c;
                e.a    = {1'b0, x[idx*128 +: 128]};
                e.b    = {1'b0, y[idx*128 +: 128]};
                e.idx  = 3'(idx);
                e.last = (c == 7);
                if (d == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endfunction

    task automatic mon_step(input int d, input logic v, input exp_t act);
        exp_t e;
        logic empty;
        if (hold[d]) chk($sformatf("d%0d_stable", d), 272'(act), 272'(saved[d]));
        if (v && out_ready) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                chk($sformatf("d%0d_unexpected_limb", d), 272'(1), 272'(0));
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("d%0d_a", d), 272'(act.a), 272'(e.a));
                chk($sformatf("d%0d_b", d), 272'(act.b), 272'(e.b));
                chk($sformatf("d%0d_idx", d), 272'(act.idx), 272'(e.idx));
                chk($sformatf("d%0d_last", d), 272'(act.last), 272'(e.last));
            end
        end
        hold[d]  = v && !out_ready;
        saved[d] = act;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold[0] = 1'b0;
            hold[1] = 1'b0;
        end else begin
            mon_step(0, out_valid0, {out_a0, out_b0, out_idx0, out_last0});
            mon_step(1, out_valid1, {out_a1, out_b1, out_idx1, out_last1});
            if (gap_watch && !out_valid0) gap_cnt++;
        end
    end

    // Leaves in_valid high after the capture edge; caller drops it when done.
    task automatic offer(input logic [1023:0] x, input logic [1023:0] y);
        logic ok;
        ok = 1'b0;
        X = x;
        Y = y;
        in_valid = 1'b1;
        push_exp(x, y);
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (in_ready0) ok = 1'b1;
        end
        if (!ok) chk("offer_timeout", 272'(0), 272'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (q0.size() != 0 || q1.size() != 0); n++) @(posedge clk);
        #1;
        chk("drain_q0", 272'(q0.size()), 272'(0));
        chk("drain_q1", 272'(q1.size()), 272'(0));
    endtask

    dvec_t         dv [5];
    ovec_t         ov [3];
    logic [1023:0] px, py;
    int            hs;
    logic          ok;

    initial begin
        for (int i = 0; i < 8; i++) begin
            px[i*128 +: 128] = 128'(i + 1);
            py[i*128 +: 128] = 128'(8'hF0 + i);
        end
        dv[0] = '{px, py};
        dv[1] = '{'1, '0};
        dv[2] = '{'0, '1};
        for (int v = 3; v < 5; v++) begin
            for (int w = 0; w < 32; w++) begin
                dv[v].x[w*32 +: 32] = $urandom;
                dv[v].y[w*32 +: 32] = $urandom;
            end
        end
        for (int j = 0; j < 8; j++) begin
            ov[0].ea[j] = (j < 7) ? 15'h1FFF : 15'h01FF;
            ov[0].eb[j] = 15'h0;
            ov[1].ea[j] = (j == 7) ? 15'h0100 : 15'h0;
            ov[1].eb[j] = (j == 0) ? 15'h0005 : 15'h0;
            ov[2].ea[j] = (j == 1) ? 15'h0001 : 15'h0;
            ov[2].eb[j] = (j < 7) ? 15'h1FFF : 15'h00FF;
        end
        ov[0].x = '1;
        ov[0].y = '0;
        ov[1].x = 100'd1 << 99;
        ov[1].y = 100'h5;
        ov[2].x = 100'd1 << 13;
        ov[2].y = {100{1'b1}} >> 1;

        #1;
        chk("rst_in_ready", 272'(in_ready0), 272'(1));
        chk("rst_out_valid", 272'(out_valid0), 272'(0));
        chk("rst_out_a", 272'(out_a0), 272'(0));
        chk("rst_out_b", 272'(out_b0), 272'(0));
        chk("rst_out_last", 272'(out_last0), 272'(0));
        chk("rst_out_idx", 272'(out_idx0), 272'(0));
        chk("rst_msb_idx", 272'(out_idx1), 272'(7));
        chk("rst_odd_ready", 272'(in_ready2), 272'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // plan operands: in_ready rises only on the last limb cycle
        offer(px, py);
        in_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("plan_out_valid", 272'(out_valid0), 272'(1));
            chk("plan_in_ready", 272'(in_ready0), 272'(j == 7));
        end
        @(posedge clk);
        #1;
        drain();

        for (int v = 0; v < 5; v++) begin
            offer(dv[v].x, dv[v].y);
            in_valid = 1'b0;
            drain();
        end

        // back-to-back: no out_valid gap across both streams
        offer(dv[3].x, dv[3].y);
        gap_cnt   = 0;
        gap_watch = 1'b1;
        offer(dv[4].x, dv[4].y);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        gap_watch = 1'b0;
        chk("b2b_gap", 272'(gap_cnt), 272'(0));
        @(posedge clk);
        #1;
        drain();

        // backpressure with out_ready pattern 1,0,0
        offer(px, py);
        in_valid = 1'b0;
        hs = 0;
        for (int k = 0; k < 60 && hs < 8; k++) begin
            out_ready = (k % 3 == 0);
            @(negedge clk);
            chk("bp_out_valid", 272'(out_valid0), 272'(1));
            chk("bp_in_ready", 272'(in_ready0), 272'(hs == 7 && out_ready));
            if (out_valid0 && out_ready) hs++;
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        chk("bp_handshakes", 272'(hs), 272'(8));
        drain();

        // mid-stream reset after limb 3 accepted
        offer(dv[3].x, dv[3].y);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", 272'(out_valid0), 272'(0));
        chk("mrst_in_ready", 272'(in_ready0), 272'(1));
        chk("mrst_out_a", 272'(out_a0), 272'(0));
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        offer(dv[4].x, dv[4].y);
        in_valid = 1'b0;
        drain();

        // odd width instance: WIDTH=100, LIMB_W=13, OUT_W=15
        for (int v = 0; v < 3; v++) begin
            X2 = ov[v].x;
            Y2 = ov[v].y;
            in_valid2 = 1'b1;
            ok = 1'b0;
            for (int n = 0; n < 64 && !ok; n++) begin
                @(negedge clk);
                if (in_ready2) ok = 1'b1;
            end
            chk("odd_capture", 272'(ok), 272'(1));
            @(posedge clk);
            #1;
            in_valid2 = 1'b0;
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                chk($sformatf("odd%0d_valid%0d", v, j), 272'(out_valid2), 272'(1));
                chk($sformatf("odd%0d_a%0d", v, j), 272'(out_a2), 272'(ov[v].ea[j]));
                chk($sformatf("odd%0d_b%0d", v, j), 272'(out_b2), 272'(ov[v].eb[j]));
                chk($sformatf("odd%0d_idx%0d", v, j), 272'(out_idx2), 272'(j));
                chk($sformatf("odd%0d_last%0d", v, j), 272'(out_last2), 272'(j == 7));
            end
            @(negedge clk);
            chk("odd_idle_ready", 272'(in_ready2), 272'(1));
            chk("odd_idle_valid", 272'(out_valid2), 272'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
